// File: rtl/sat_accumulator_mc.sv
// ---------------------------------------------------------------------------
// sat_accumulator_mc
//
// Multi-channel symmetric-saturating accumulator. Each accepted signed sample
// is added to the accumulator of its tagged channel. The result is clamped to
// +/-(2^(WIDTH_ACC-1)-1), so the most negative code 100..0 is never produced.
// The saturated value is stored back, which means clamping persists across
// later adds instead of wrapping. Results leave through a single
// valid/ready output register that has no skid buffer.
//
// Optional feature macro: SAT_STICKY_FLAGS_EN
//   defined   : sat_flags_80 holds a sticky per-channel saturation bit.
//               flag_clr_80 clears all bits. A same-cycle set wins for its
//               channel.
//   undefined : sat_flags_80 is tied to 0 and flag_clr_80 is ignored.
//
// Ports
//   clk_80        in   clock; all state updates on the rising edge
//   reset_80      in   synchronous, active-high reset
//   in_valid_80   in   input sample valid
//   in_ready_80   out  block can accept a sample this cycle
//   in_data_80    in   signed sample, WIDTH_IN bits
//   in_ch_80      in   target channel index, CH_W bits
//   in_clr_80     in   restart channel: acc[ch] = sample (no add)
//   out_valid_80  out  result valid
//   out_ready_80  in   downstream accepts result
//   out_data_80   out  saturated accumulator value after update
//   out_ch_80     out  channel of out_data_80
//   out_sat_80    out  this update was clamped or corrected
//   sat_flags_80  out  sticky per-channel saturation flags
//   flag_clr_80   in   clears all sat_flags_80
// ---------------------------------------------------------------------------
module sat_accumulator_mc #(
    parameter int WIDTH_IN  = 4,
    parameter int WIDTH_ACC = 8,
    parameter int CHANNELS  = 4,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                 clk_80,
    input  logic                 reset_80,
    input  logic                 in_valid_80,
    output logic                 in_ready_80,
    input  logic [WIDTH_IN-1:0]  in_data_80,
    input  logic [CH_W-1:0]      in_ch_80,
    input  logic                 in_clr_80,
    output logic                 out_valid_80,
    input  logic                 out_ready_80,
    output logic [WIDTH_ACC-1:0] out_data_80,
    output logic [CH_W-1:0]      out_ch_80,
    output logic                 out_sat_80,
    output logic [CHANNELS-1:0]  sat_flags_80,
    input  logic                 flag_clr_80
);

    localparam logic [WIDTH_IN-1:0]         IN_MIN   = {1'b1, {(WIDTH_IN-1){1'b0}}};
    localparam logic [WIDTH_IN-1:0]         IN_ONE   = {{(WIDTH_IN-1){1'b0}}, 1'b1};
    localparam logic signed [WIDTH_ACC:0]   SUM_ONE  = {{WIDTH_ACC{1'b0}}, 1'b1};
    localparam logic signed [WIDTH_ACC:0]   MAX_POS  = {2'b00, {(WIDTH_ACC-1){1'b1}}};
    localparam logic signed [WIDTH_ACC:0]   NEG_LIM  = {2'b11, {(WIDTH_ACC-1){1'b0}}};
    localparam logic signed [WIDTH_ACC:0]   NEG_SATW = NEG_LIM + SUM_ONE;
    localparam logic [WIDTH_ACC-1:0]        POS_SAT  = MAX_POS[WIDTH_ACC-1:0];
    localparam logic [WIDTH_ACC-1:0]        NEG_SAT  = NEG_SATW[WIDTH_ACC-1:0];

    logic [WIDTH_ACC-1:0]       acc_mem [CHANNELS];

    logic                       accept;
    logic                       ch_valid;
    logic                       in_corrected;
    logic signed [WIDTH_IN-1:0] x_corr;
    logic signed [WIDTH_ACC:0]  x_ext;
    logic signed [WIDTH_ACC:0]  base_ext;
    logic signed [WIDTH_ACC:0]  sum;
    logic [WIDTH_ACC-1:0]       result;
    logic                       result_sat;

    // Single output register without skid buffer: a new sample can only be
    // taken when the register is empty or is being drained this cycle.
    assign in_ready_80 = !reset_80 && (!out_valid_80 || out_ready_80);
    assign accept      = in_valid_80 && in_ready_80;

    // Widening the channel index keeps the range check valid for channel
    // counts that are not a power of two.
    assign ch_valid = ({{(32-CH_W){1'b0}}, in_ch_80} < 32'(CHANNELS));

    // Datapath: correct the most negative input code, add to the selected
    // accumulator (or to zero on a restart) one bit wider than the stored
    // value, then clamp symmetrically.
    always_comb begin
        in_corrected = 1'b0;
        x_corr       = in_data_80;
        x_ext        = '0;
        base_ext     = '0;
        sum          = '0;
        result       = '0;
        result_sat   = 1'b0;

        if (in_data_80 == IN_MIN) begin
            in_corrected = 1'b1;
            x_corr       = in_data_80 + IN_ONE;
        end

        x_ext = {{(WIDTH_ACC+1-WIDTH_IN){x_corr[WIDTH_IN-1]}}, x_corr};

        if (ch_valid && !in_clr_80) begin
            base_ext = {acc_mem[in_ch_80][WIDTH_ACC-1], acc_mem[in_ch_80]};
        end

        sum = base_ext + x_ext;

        if (!ch_valid) begin
            result     = '0;
            result_sat = 1'b1;
        end else if (sum > MAX_POS) begin
            result     = POS_SAT;
            result_sat = 1'b1;
        end else if (sum <= NEG_LIM) begin
            result     = NEG_SAT;
            result_sat = 1'b1;
        end else begin
            result     = sum[WIDTH_ACC-1:0];
            result_sat = in_corrected;
        end
    end

    // Accumulator bank: only the addressed, in-range channel is written, so
    // an out-of-range sample leaves every accumulator untouched.
    always_ff @(posedge clk_80) begin
        if (reset_80) begin
            for (int i = 0; i < CHANNELS; i++) begin
                acc_mem[i] <= '0;
            end
        end else if (accept && ch_valid) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if ({{(32-CH_W){1'b0}}, in_ch_80} == 32'(i)) begin
                    acc_mem[i] <= result;
                end
            end
        end
    end

    // Output register: a new accept overwrites it (the old result is being
    // drained in the same cycle), otherwise a completed handshake empties it.
    always_ff @(posedge clk_80) begin
        if (reset_80) begin
            out_valid_80 <= 1'b0;
            out_data_80  <= '0;
            out_ch_80    <= '0;
            out_sat_80   <= 1'b0;
        end else if (accept) begin
            out_valid_80 <= 1'b1;
            out_data_80  <= result;
            out_ch_80    <= in_ch_80;
            out_sat_80   <= result_sat;
        end else if (out_valid_80 && out_ready_80) begin
            out_valid_80 <= 1'b0;
        end
    end

`ifdef SAT_STICKY_FLAGS_EN
    logic [CHANNELS-1:0] flags_q;

    // Sticky flags: clear-all first, then a saturating accept on a valid
    // channel sets its bit, so a same-cycle set beats the clear.
    always_ff @(posedge clk_80) begin
        if (reset_80) begin
            flags_q <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (accept && ch_valid && result_sat &&
                    ({{(32-CH_W){1'b0}}, in_ch_80} == 32'(i))) begin
                    flags_q[i] <= 1'b1;
                end else if (flag_clr_80) begin
                    flags_q[i] <= 1'b0;
                end
            end
        end
    end

    assign sat_flags_80 = flags_q;
`else
    logic unused_flag_clr;

    assign unused_flag_clr = flag_clr_80;
    assign sat_flags_80    = '0;
`endif

endmodule

// File: tb/tb_sat_accumulator_mc.sv
// ---------------------------------------------------------------------------
// tb_sat_accumulator_mc
//
// Scoreboard bench for sat_accumulator_mc (WIDTH_IN=4, WIDTH_ACC=8,
// CHANNELS=4). The driver computes each expected result from an integer
// model of the accumulators and queues it. The monitor compares whatever the
// DUT presents against the head of the queue. Define SAT_STICKY_FLAGS_EN to
// also model the sticky flags.
// ---------------------------------------------------------------------------
module tb_sat_accumulator_mc;

    localparam int WIDTH_IN  = 4;
    localparam int WIDTH_ACC = 8;
    localparam int CHANNELS  = 4;
    localparam int CH_W      = 2;
    localparam int MAXV      = 127;

    logic                 clk_80 = 1'b0;
    logic                 reset_80 = 1'b1;
    logic                 in_valid_80 = 1'b0;
    logic                 in_ready_80;
    logic [WIDTH_IN-1:0]  in_data_80 = '0;
    logic [CH_W-1:0]      in_ch_80 = '0;
    logic                 in_clr_80 = 1'b0;
    logic                 out_valid_80;
    logic                 out_ready_80 = 1'b1;
    logic [WIDTH_ACC-1:0] out_data_80;
    logic [CH_W-1:0]      out_ch_80;
    logic                 out_sat_80;
    logic [CHANNELS-1:0]  sat_flags_80;
    logic                 flag_clr_80 = 1'b0;

    typedef struct {
        int data;
        int ch;
        int sat;
    } exp_t;

    exp_t q[$];
    int   acc_m [CHANNELS];
    int   flags_m = 0;
    int   tests = 0;
    int   fails = 0;

    sat_accumulator_mc #(
        .WIDTH_IN (WIDTH_IN),
        .WIDTH_ACC(WIDTH_ACC),
        .CHANNELS (CHANNELS)
    ) dut (
        .clk_80      (clk_80),
        .reset_80    (reset_80),
        .in_valid_80 (in_valid_80),
        .in_ready_80 (in_ready_80),
        .in_data_80  (in_data_80),
        .in_ch_80    (in_ch_80),
        .in_clr_80   (in_clr_80),
        .out_valid_80(out_valid_80),
        .out_ready_80(out_ready_80),
        .out_data_80 (out_data_80),
        .out_ch_80   (out_ch_80),
        .out_sat_80  (out_sat_80),
        .sat_flags_80(sat_flags_80),
        .flag_clr_80 (flag_clr_80)
    );

    always #5 clk_80 = ~clk_80;

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference rules: fold -8 to -7, add (or restart), clamp to +/-127.
    function automatic exp_t modelStep(input int x_raw, input int ch, input bit clr);
        exp_t e;
        int   x;
        int   s;
        bit   corr;
        e.ch = ch;
        corr = (x_raw == -8);
        x = corr ? -7 : x_raw;
        if (ch >= CHANNELS) begin
            e.data = 0;
            e.sat  = 1;
        end else begin
            s = clr ? x : acc_m[ch] + x;
            if (s > MAXV) begin
                e.data = MAXV;
                e.sat  = 1;
            end else if (s < -MAXV) begin
                e.data = -MAXV;
                e.sat  = 1;
            end else begin
                e.data = s;
                e.sat  = corr ? 1 : 0;
            end
        end
        return e;
    endfunction

    // One cycle of stimulus: drive after the falling edge, predict the
    // handshake from the queue occupancy, update the model, check flags and
    // (on reset) the cleared output state just after the rising edge.
    task automatic applyStimulus(input bit v, input int data, input int ch, input bit clr,
                                 input bit ordy, input bit fclr, input bit rst);
        exp_t e;
        bit   exp_ready;
        @(negedge clk_80);
        reset_80     = rst;
        in_valid_80  = v;
        in_data_80   = 4'(data);
        in_ch_80     = 2'(ch);
        in_clr_80    = clr;
        out_ready_80 = ordy;
        flag_clr_80  = fclr;
        #1;
        exp_ready = !rst && ((q.size() == 0) || ordy);
        checkOutput("in_ready", int'(in_ready_80), int'(exp_ready));
        if (rst) begin
            q.delete();
            foreach (acc_m[i]) acc_m[i] = 0;
            flags_m = 0;
        end else begin
`ifdef SAT_STICKY_FLAGS_EN
            if (fclr) flags_m = 0;
`endif
            if (v && exp_ready) begin
                e = modelStep(data, ch, clr);
                q.push_back(e);
                if (ch < CHANNELS) begin
                    acc_m[ch] = e.data;
`ifdef SAT_STICKY_FLAGS_EN
                    if (e.sat != 0) flags_m = flags_m | (1 << ch);
`endif
                end
            end
        end
        @(posedge clk_80);
        #1;
        checkOutput("sat_flags", int'(sat_flags_80), flags_m);
        if (rst) begin
            checkOutput("rst_out_valid", int'(out_valid_80), 0);
            checkOutput("rst_out_data", int'(out_data_80), 0);
            checkOutput("rst_out_ch", int'(out_ch_80), 0);
            checkOutput("rst_out_sat", int'(out_sat_80), 0);
        end
    endtask

    // Monitor: compares the presented result every cycle (so a stalled
    // output must stay stable) and retires it on a completed handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_80);
            #3;
            if (!reset_80 && out_valid_80) begin
                if (q.size() == 0) begin
                    checkOutput("unexpected_out_valid", 1, 0);
                end else begin
                    e = q[0];
                    checkOutput("out_data", int'($signed(out_data_80)), e.data);
                    checkOutput("out_ch", int'(out_ch_80), e.ch);
                    checkOutput("out_sat", int'(out_sat_80), e.sat);
                    if (out_ready_80) void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int waited;
        foreach (acc_m[i]) acc_m[i] = 0;

        $display("[TB] reset");
        applyStimulus(0, 0, 0, 0, 1, 0, 1);
        applyStimulus(1, 7, 0, 0, 1, 0, 1);

        $display("[TB] ch0 +7 x3");
        for (int i = 0; i < 3; i++) applyStimulus(1, 7, 0, 0, 1, 0, 0);

        $display("[TB] ch1 +7 x20, positive clamp");
        for (int i = 0; i < 20; i++) applyStimulus(1, 7, 1, 0, 1, 0, 0);

        $display("[TB] ch2 corrected restart, negative clamp");
        applyStimulus(1, -8, 2, 1, 1, 0, 0);
        for (int i = 0; i < 20; i++) applyStimulus(1, -7, 2, 0, 1, 0, 0);
        applyStimulus(1, -8, 2, 0, 1, 0, 0);

        $display("[TB] backpressure");
        applyStimulus(1, 3, 3, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 5, 3, 0, 0, 0, 0);
        applyStimulus(1, 5, 3, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);

        $display("[TB] sticky flags clear vs set");
        applyStimulus(1, 7, 1, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        applyStimulus(1, 7, 1, 0, 1, 1, 0);
        applyStimulus(1, 1, 0, 0, 1, 1, 0);

        $display("[TB] interleave, then reset mid-stream");
        for (int i = 0; i < 6; i++) applyStimulus(1, i - 3, (i % 2) ? 3 : 0, 0, 1, 0, 0);
        applyStimulus(1, 4, 0, 0, 0, 0, 0);
        applyStimulus(1, 4, 0, 0, 1, 0, 1);
        for (int c = 0; c < CHANNELS; c++) applyStimulus(1, 0, c, 0, 1, 0, 0);

        $display("[TB] random phase");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(3) != 0),
                          int'($signed(4'($urandom_range(15)))),
                          int'($urandom_range(CHANNELS - 1)),
                          ($urandom_range(7) == 0),
                          ($urandom_range(9) < 7),
                          ($urandom_range(15) == 0),
                          ($urandom_range(99) == 0));
        end

        waited = 0;
        while (q.size() != 0 && waited < 20) begin
            applyStimulus(0, 0, 0, 0, 1, 0, 0);
            waited++;
        end
        checkOutput("drain_queue_empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
